// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, the NOP
// seed for an empty queue head, and the fetch queue entry layout.
package fetch_pkg;

    localparam int FETCH_AW = 32;
    localparam int FETCH_DW = 32;

    localparam logic [FETCH_DW-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_DW-1:0] instr;
        logic [FETCH_AW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch queue. Slot 0 is always the head; a flush wins over push/pop.
// The head's pc+4 is kept in its own register so decode sees no adder path.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter logic [FETCH_AW-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  fetch_entry_t        push_entry,
    output fetch_entry_t        head,
    output logic [FETCH_AW-1:0] head_pc_plus4,
    output logic [1:0]          occ
);

    fetch_entry_t        slot0, slot1;
    logic [FETCH_AW-1:0] pc4_q;
    logic [1:0]          occ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0 <= '{instr: NOP_INSTR, pc: RESET_PC};
            slot1 <= '{instr: NOP_INSTR, pc: RESET_PC};
            pc4_q <= RESET_PC + FETCH_AW'(4);
            occ_q <= 2'd0;
        end else if (flush) begin
            occ_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        slot0 <= push_entry;
                        pc4_q <= push_entry.pc + FETCH_AW'(4);
                    end else begin
                        slot1 <= push_entry;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    pc4_q <= slot1.pc + FETCH_AW'(4);
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (occ_q == 2'd1) begin
                        slot0 <= push_entry;
                        pc4_q <= push_entry.pc + FETCH_AW'(4);
                    end else begin
                        slot0 <= slot1;
                        pc4_q <= slot1.pc + FETCH_AW'(4);
                        slot1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head          = slot0;
    assign head_pc_plus4 = pc4_q;
    assign occ           = occ_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one request at a time to
// instruction memory, buffers results for decode and handles redirects.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                 A_WIDTH  = FETCH_AW,
    parameter int                 D_WIDTH  = FETCH_DW,
    parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_pc,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic               if_valid,
    output logic [D_WIDTH-1:0] if_instr,
    output logic [A_WIDTH-1:0] if_pc,
    output logic [A_WIDTH-1:0] if_pc_plus4,
    input  logic               id_ready
);

    fetch_state_e       state_q, state_d;
    logic [A_WIDTH-1:0] fetch_pc, fetch_pc_d, req_addr, redirect_tgt;
    logic [1:0]         occ;
    logic               fire, hold, push, pop;
    fetch_entry_t       push_entry, head;
    logic [A_WIDTH-1:0] head_pc4;
    logic               unused_redirect_lsb;

    assign redirect_tgt        = {redirect_pc[A_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // occ only rises on an ack, so a raised request stays up until acked.
    assign imem_req  = (state_q == DRAIN) || ((state_q == FETCH) && (occ != 2'd2));
    assign imem_addr = req_addr;
    assign fire      = imem_req && imem_ack;
    assign hold      = imem_req && !imem_ack;
    assign push      = fire && (state_q == FETCH) && !redirect_valid;
    assign pop       = if_valid && id_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (redirect_valid && hold) state_d = DRAIN;
            DRAIN:   if (fire) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (redirect_valid)
            fetch_pc_d = redirect_tgt;
        else if (push)
            fetch_pc_d = req_addr + A_WIDTH'(4);
    end

    // req_addr tracks fetch_pc except while a request is being held for its ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state_q  <= state_d;
            fetch_pc <= fetch_pc_d;
            if (!hold)
                req_addr <= fetch_pc_d;
        end
    end

    assign push_entry = '{instr: imem_rdata, pc: req_addr};

    fetch_buf #(
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .flush         (redirect_valid),
        .push_entry    (push_entry),
        .head          (head),
        .head_pc_plus4 (head_pc4),
        .occ           (occ)
    );

    assign if_valid    = (occ != 2'd0) && !redirect_valid;
    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head_pc4;

endmodule
